// File: rtl/msk_aes_rcon_sched_pkg.sv
// rtl/msk_aes_rcon_sched_pkg.sv - key-mode encodings, schedule tables, GF(2^8) helpers, FSM states
package msk_aes_rcon_sched_pkg;

  typedef enum logic [1:0] {
    KM_128 = 2'b00,
    KM_192 = 2'b01,
    KM_256 = 2'b10,
    KM_RSV = 2'b11
  } key_mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [7:0] RCON_FIRST = 8'h01;

  // Number of round constants consumed by each key size.
  function automatic logic [3:0] rcon_count(key_mode_e km);
    case (km)
      KM_192:  rcon_count = 4'd8;
      KM_256:  rcon_count = 4'd7;
      default: rcon_count = 4'd10;
    endcase
  endfunction

  function automatic logic [7:0] rcon_final(key_mode_e km);
    case (km)
      KM_192:  rcon_final = 8'h80;
      KM_256:  rcon_final = 8'h40;
      default: rcon_final = 8'h36;
    endcase
  endfunction

  function automatic logic [7:0] xtime(logic [7:0] x);
    xtime = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
  endfunction

  function automatic logic [7:0] xtime_inv(logic [7:0] x);
    xtime_inv = x[0] ? (((x ^ 8'h1b) >> 1) | 8'h80) : (x >> 1);
  endfunction

endpackage

// File: rtl/msk_aes_rcon_sched_if.sv
// rtl/msk_aes_rcon_sched_if.sv - control and share bus of the round-constant sequencer
interface msk_aes_rcon_sched_if #(
  parameter int d     = 2,
  parameter int CNT_W = 4
);
  logic             start;
  logic [1:0]       key_mode;
  logic             inverse;
  logic             update;
  logic             mask_rcon;
  logic [8*d-1:0]   sh_rcon;
  logic             busy;
  logic             last;
  logic [CNT_W-1:0] step_idx;
  logic             mode_err;

  modport master (
    output start, key_mode, inverse, update, mask_rcon,
    input  sh_rcon, busy, last, step_idx, mode_err
  );

  modport slave (
    input  start, key_mode, inverse, update, mask_rcon,
    output sh_rcon, busy, last, step_idx, mode_err
  );
endinterface

// File: rtl/msk_aes_rcon_sched_cst.sv
// rtl/msk_aes_rcon_sched_cst.sv - constant d-share sharing (x, 0, ..., 0); consumes no randomness
module msk_aes_rcon_sched_cst #(
  parameter int d     = 2,
  parameter int count = 8
) (
  input  logic [count-1:0]   x,
  output logic [count*d-1:0] sh
);
  always_comb begin
    sh            = '0;
    sh[count-1:0] = x;
  end
endmodule

// File: rtl/msk_aes_rcon_sched.sv
// rtl/msk_aes_rcon_sched.sv - masked AES rcon sequencer, forward or inverse, for 128/192/256 keys
module msk_aes_rcon_sched
  import msk_aes_rcon_sched_pkg::*;
#(
  parameter int d     = 2,
  parameter int CNT_W = 4
) (
  input logic                    clk,
  input logic                    rst_n,
  msk_aes_rcon_sched_if.slave    bus
);

  state_e           state_q, state_d;
  logic [7:0]       rcon_q, rcon_d;
  logic [CNT_W-1:0] step_q, step_d;
  key_mode_e        km_q, km_d;
  logic             inv_q, inv_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] step_last;
  logic [7:0]       rcon_gated;
  logic [8*d-1:0]   sh;

  assign step_last = CNT_W'(rcon_count(km_q) - 4'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rcon_q  <= RCON_FIRST;
      step_q  <= '0;
      km_q    <= KM_128;
      inv_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rcon_q  <= rcon_d;
      step_q  <= step_d;
      km_q    <= km_d;
      inv_q   <= inv_d;
      err_q   <= err_d;
    end
  end

  // A start while running restarts the schedule; a reserved mode aborts to idle.
  always_comb begin
    state_d = state_q;
    rcon_d  = rcon_q;
    step_d  = step_q;
    km_d    = km_q;
    inv_d   = inv_q;
    err_d   = err_q;
    if (bus.start) begin
      if (key_mode_e'(bus.key_mode) == KM_RSV) begin
        state_d = ST_IDLE;
        rcon_d  = RCON_FIRST;
        step_d  = '0;
        err_d   = 1'b1;
      end else begin
        state_d = ST_RUN;
        km_d    = key_mode_e'(bus.key_mode);
        inv_d   = bus.inverse;
        rcon_d  = bus.inverse ? rcon_final(key_mode_e'(bus.key_mode)) : RCON_FIRST;
        step_d  = '0;
        err_d   = 1'b0;
      end
    end else if (state_q == ST_RUN && bus.update) begin
      if (step_q == step_last) begin
        state_d = ST_IDLE;
        rcon_d  = RCON_FIRST;
        step_d  = '0;
      end else begin
        rcon_d  = inv_q ? xtime_inv(rcon_q) : xtime(rcon_q);
        step_d  = step_q + CNT_W'(1);
      end
    end
  end

  assign bus.busy     = (state_q == ST_RUN);
  assign bus.last     = bus.busy & (step_q == step_last);
  assign bus.step_idx = step_q;
  assign bus.mode_err = err_q;
  assign rcon_gated   = rcon_q & {8{bus.mask_rcon & bus.busy}};

  (* keep_hierarchy = "yes" *)
  msk_aes_rcon_sched_cst #(
    .d     (d),
    .count (8)
  ) u_cst (
    .x  (rcon_gated),
    .sh (sh)
  );

  assign bus.sh_rcon = sh;

endmodule

// File: tb/tb_msk_aes_rcon_sched.sv
// tb/tb_msk_aes_rcon_sched.sv - self-checking bench for msk_aes_rcon_sched
module tb_msk_aes_rcon_sched;
  localparam int D  = 3;
  localparam int CW = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  msk_aes_rcon_sched_if #(.d(D), .CNT_W(CW)) bus ();

  msk_aes_rcon_sched #(.d(D), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  bit       m_busy;
  int       m_idx;
  int       m_mode;
  bit       m_inv;
  bit       m_err;
  bit       cur_mask;

  function automatic int n_rcon(int mode);
    return (mode == 0) ? 10 : (mode == 1) ? 8 : 7;
  endfunction

  // 2^k in GF(2^8), reduced by polynomial long division modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_pow2(int k);
    logic [15:0] v;
    v = 16'd1 << k;
    for (int b = 15; b >= 8; b--)
      if (v[b]) v = v ^ (16'h011b << (b - 8));
    return v[7:0];
  endfunction

  function automatic logic [7:0] exp_rcon(int mode, bit inv, int idx);
    return gf_pow2(inv ? (n_rcon(mode) - 1 - idx) : idx);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [8*D-1:0] e_sh;
    e_sh = '0;
    if (m_busy && cur_mask) e_sh[7:0] = exp_rcon(m_mode, m_inv, m_idx);
    chk("busy", 32'(bus.busy), 32'(m_busy));
    chk("last", 32'(bus.last), 32'(m_busy && (m_idx == n_rcon(m_mode) - 1)));
    chk("step_idx", 32'(bus.step_idx), 32'(m_idx));
    chk("mode_err", 32'(bus.mode_err), 32'(m_err));
    chk("sh_rcon", 32'(bus.sh_rcon), 32'(e_sh));
  endtask

  task automatic cycle(bit st, int km, bit inv, bit upd, bit mask);
    bus.start     = st;
    bus.key_mode  = km[1:0];
    bus.inverse   = inv;
    bus.update    = upd;
    bus.mask_rcon = mask;
    cur_mask      = mask;
    @(posedge clk);
    if (st) begin
      if (km == 3) begin
        m_busy = 0; m_idx = 0; m_err = 1;
      end else begin
        m_busy = 1; m_idx = 0; m_mode = km; m_inv = inv; m_err = 0;
      end
    end else if (m_busy && upd) begin
      if (m_idx == n_rcon(m_mode) - 1) begin
        m_busy = 0; m_idx = 0;
      end else begin
        m_idx++;
      end
    end
    #1;
    check_outputs();
  endtask

  task automatic run_sched(int km, bit inv);
    cycle(1, km, inv, 0, 1);
    for (int i = 0; i < n_rcon(km); i++) cycle(0, 0, 0, 1, 1);
  endtask

  logic [7:0] fwd128 [10];

  initial begin
    checks = 0; errors = 0;
    m_busy = 0; m_idx = 0; m_mode = 0; m_inv = 0; m_err = 0; cur_mask = 0;
    fwd128 = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    bus.start = 0; bus.key_mode = 0; bus.inverse = 0; bus.update = 0; bus.mask_rcon = 0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    rst_n = 1'b1;
    cycle(0, 0, 0, 0, 1);

    // AES-128 forward against a literal table
    cycle(1, 0, 0, 0, 1);
    chk("t2_rcon0", 32'(bus.sh_rcon[7:0]), 32'(fwd128[0]));
    for (int i = 1; i < 10; i++) begin
      cycle(0, 0, 0, 1, 1);
      chk("t2_rcon", 32'(bus.sh_rcon[7:0]), 32'(fwd128[i]));
    end
    chk("t2_last36", 32'(bus.last), 32'd1);
    cycle(0, 0, 0, 1, 1);
    chk("t2_done", 32'(bus.busy), 32'd0);

    run_sched(0, 1);
    run_sched(1, 0);
    run_sched(2, 1);
    run_sched(2, 0);
    run_sched(1, 1);

    // reserved mode and recovery
    cycle(1, 3, 0, 0, 1);
    chk("t5_err", 32'(bus.mode_err), 32'd1);
    cycle(0, 0, 0, 0, 1);
    cycle(1, 0, 0, 0, 1);
    chk("t5_clr", 32'(bus.mode_err), 32'd0);

    // restart at step 4, mask off, idle update
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 1);
    cycle(1, 0, 0, 1, 1);
    chk("t6_restart", 32'(bus.sh_rcon[7:0]), 32'h01);
    cycle(0, 0, 0, 1, 0);
    for (int i = 0; i < 9; i++) cycle(0, 0, 0, 1, 1);
    cycle(0, 0, 0, 1, 1);
    cycle(0, 0, 0, 1, 1);

    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 9) == 0, int'($urandom_range(0, 3)), 1'($urandom),
            1'($urandom), $urandom_range(0, 3) != 0);

    // asynchronous reset in the middle of a schedule
    cycle(1, 1, 0, 0, 1);
    cycle(0, 0, 0, 1, 1);
    cycle(0, 0, 0, 1, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t1_busy", 32'(bus.busy), 32'd0);
    chk("t1_sh", 32'(bus.sh_rcon), 32'd0);
    chk("t1_step", 32'(bus.step_idx), 32'd0);
    m_busy = 0; m_idx = 0; m_err = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(0, 0, 0, 1, 1);
    cycle(0, 0, 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
